count_sequencer: RTL and testbench

Command-side controller for the team's loadable down-counter (ports `count_to`, `load`, `count_en`, `done`). It accepts a stream of count values over a valid/ready handshake and buffers them in a small FIFO. For each value it drives one complete run: load, enable, and wait for `done`. When the run ends it reports completion. It sits between a software/CPU-facing request path and one counter instance.

---
 rtl/count_sequencer_pkg.sv | 21 ++
 rtl/count_sequencer_fifo.sv | 69 ++++++
 rtl/count_sequencer.sv | 111 +++++++++++
 tb/tb_count_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared types and defaults for the count sequencer and its request FIFO.
package count_seq_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DEPTH = 4;

    // Sequencer FSM states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // True for every state in which a run is in progress.
    function automatic logic state_is_busy(input state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/count_sequencer_fifo.sv
// Small synchronous request FIFO with first-word-fall-through output and flush.
module seq_fifo
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    // Flush wins over both push and pop so a flushing cycle leaves the FIFO empty.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because count_q gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-side controller: queues count values and drives one load/settle/run
// cycle on an attached down-counter per value, reporting each completed run.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_value,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt_count_to,
    output logic             cnt_load,
    output logic             cnt_count_en,
    input  logic             cnt_done,
    output logic             busy,
    output logic             run_done,
    output logic [7:0]       runs_completed
);

    state_e           state_q, state_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_push;
    logic             fifo_pop;

    logic [WIDTH-1:0] count_to_q;
    logic             load_q;
    logic             count_en_q;
    logic             run_done_q;
    logic [7:0]       runs_q;

    assign req_ready = !fifo_full && !abort;
    assign fifo_push = req_valid && req_ready;
    // The head leaves the FIFO on the edge that enters LOAD; abort already forces IDLE.
    assign fifo_pop  = (state_d == ST_LOAD);

    seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (abort),
        .din     (req_value),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = cnt_done ? ST_FINISH : ST_RUN;
            ST_RUN:    if (cnt_done) state_d = ST_FINISH;
            ST_FINISH: state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Registered counter strobes and completion reporting, decoded from the next state
    // so each strobe is aligned with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_to_q <= '0;
            load_q     <= 1'b0;
            count_en_q <= 1'b0;
            run_done_q <= 1'b0;
            runs_q     <= '0;
        end else begin
            load_q     <= (state_d == ST_LOAD);
            count_en_q <= (state_d == ST_RUN);
            run_done_q <= (state_d == ST_FINISH);
            if (fifo_pop) begin
                count_to_q <= fifo_dout;
            end
            if (state_d == ST_FINISH) begin
                runs_q <= runs_q + 8'd1;
            end
        end
    end

    assign cnt_count_to   = count_to_q;
    assign cnt_load       = load_q;
    assign cnt_count_en   = count_en_q;
    assign run_done       = run_done_q;
    assign runs_completed = runs_q;
    assign busy           = state_is_busy(state_q);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: behavioural down-counter, directed vector table,
// multi-cycle corner sequences and a randomized phase against a queue-based model.
module tb_count_sequencer;

    localparam int W     = 3;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_value;
    logic         abort;
    logic [W-1:0] cnt_count_to;
    logic         cnt_load;
    logic         cnt_count_en;
    logic         cnt_done;
    logic         busy;
    logic         run_done;
    logic [7:0]   runs_completed;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    count_sequencer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_value      (req_value),
        .abort          (abort),
        .cnt_count_to   (cnt_count_to),
        .cnt_load       (cnt_load),
        .cnt_count_en   (cnt_count_en),
        .cnt_done       (cnt_done),
        .busy           (busy),
        .run_done       (run_done),
        .runs_completed (runs_completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter being sequenced: load wins, else decrement while enabled and nonzero.
    logic [W-1:0] cnt_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     cnt_q <= '0;
        else if (cnt_load)                cnt_q <= cnt_count_to;
        else if (cnt_count_en && cnt_q != 0) cnt_q <= cnt_q - 1'b1;
    end
    assign cnt_done = (cnt_q == 0);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Queue of accepted-but-not-loaded values (= FIFO contents), one run in flight,
    // and a modular tally of completed runs.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_v;
    bit           pending;
    int           pend_done;
    bit           exp_load;
    bit           prev_rd;
    logic [7:0]   runs_model;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            pending    = 0;
            exp_load   = 0;
            prev_rd    = 0;
            runs_model = 8'd0;
        end else begin
            if (cnt_load || exp_load) check("load_when_due", int'(cnt_load), int'(exp_load));
            if (cnt_load) begin
                if (exp_q.size() == 0) begin
                    check("load_from_empty", 1, 0);
                end else begin
                    mon_v = exp_q.pop_front();
                    check("load_value", int'(cnt_count_to), int'(mon_v));
                    pending   = 1;
                    pend_done = cyc + ((mon_v == 0) ? 2 : int'(mon_v) + 3);
                end
            end
            if (run_done) begin
                check("done_pending", int'(pending), 1);
                if (pending) check("done_cycle", cyc, pend_done);
                check("done_width", int'(prev_rd), 0);
                check("done_counter_zero", int'(cnt_q), 0);
                pending    = 0;
                runs_model = runs_model + 8'd1;
                check("runs_completed", int'(runs_completed), int'(runs_model));
            end else if (pending && cyc > pend_done) begin
                check("done_timeout", 0, 1);
                pending = 0;
            end
            check("req_ready", int'(req_ready), int'((exp_q.size() < DEPTH) && !abort));
            exp_load = !abort && (exp_q.size() > 0) && (run_done || !busy);
            if (abort) begin
                exp_q.delete();
                pending = 0;
            end
            if (req_valid && req_ready) exp_q.push_back(req_value);
            prev_rd = run_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold req_valid with value v until accepted; returns just after the accepting edge.
    task automatic push_hold(input logic [W-1:0] v);
        bit ok = 0;
        req_valid = 1'b1;
        req_value = v;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            tick();
        end
        req_valid = 1'b0;
        if (!ok) check("push_accept", 0, 1);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 600 && quiet < 2; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        check("wait_idle", quiet, 2);
        tick();
    endtask

    // which: 0 = cnt_load, 1 = run_done, 2 = cnt_count_en. Returns at the negedge it is seen.
    task automatic wait_until(input int which, input string name);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = cnt_load;
                1:       hit = run_done;
                default: hit = cnt_count_en;
            endcase
        end
        check(name, int'(hit), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},   int'(req_ready), 1);
        check({tag, "_count_to"},    int'(cnt_count_to), 0);
        check({tag, "_load"},        int'(cnt_load), 0);
        check({tag, "_count_en"},    int'(cnt_count_en), 0);
        check({tag, "_busy"},        int'(busy), 0);
        check({tag, "_run_done"},    int'(run_done), 0);
        check({tag, "_runs"},        int'(runs_completed), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [W-1:0] value;
        int           acc_to_load;
        int           load_to_done;
        int           run_cycles;
    } vec_t;

    vec_t       vecs[6];
    logic [W-1:0] lv[8];
    int         lc[8];
    int         dc[8];
    int         nl, nd, gaps, acc, lds, occ_at, wide, rc;
    bit         saw_nr, saw255;
    logic [W-1:0] vals4[6];

    initial begin
        // Watchdog: never hang.
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int accept_c, load_c, done_c, run_cnt, extra_load;

        vecs[0] = '{3'd7, 1, 10, 8};
        vecs[1] = '{3'd0, 1,  2, 0};
        vecs[2] = '{3'd1, 1,  4, 2};
        vecs[3] = '{3'd4, 1,  7, 5};
        vecs[4] = '{3'd2, 1,  5, 3};
        vecs[5] = '{3'd6, 1,  9, 7};

        reset_n = 1'b0; req_valid = 1'b0; req_value = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        tick();

        // Directed single runs from idle: latency and RUN length per value.
        foreach (vecs[k]) begin
            rc = runs_completed;
            push_hold(vecs[k].value);
            accept_c = cyc;
            wait_until(0, "vec_load_seen");
            load_c = cyc;
            run_cnt = 0; extra_load = 0;
            for (int i = 0; i < 40 && !run_done; i++) begin
                @(negedge clk);
                if (cnt_count_en) run_cnt++;
                if (cnt_load) extra_load++;
            end
            done_c = cyc;
            check("vec_accept_to_load", load_c - accept_c, vecs[k].acc_to_load);
            check("vec_load_to_done", done_c - load_c, vecs[k].load_to_done);
            check("vec_run_cycles", run_cnt, vecs[k].run_cycles);
            check("vec_load_one_cycle", extra_load, 0);
            check("vec_counter_zero", int'(cnt_q), 0);
            check("vec_runs", int'(runs_completed), (rc + 1) % 256);
            tick();
        end

        // Back-to-back 3, 0, 5: no IDLE between runs.
        wait_idle();
        rc = runs_completed; nl = 0; nd = 0; gaps = 0;
        fork
            begin
                push_hold(3'd3); push_hold(3'd0); push_hold(3'd5);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (cnt_load && nl < 3) begin lv[nl] = cnt_count_to; lc[nl] = cyc; nl++; end
                    if (run_done && nd < 3) begin dc[nd] = cyc; nd++; end
                    if (nl > 0 && nd < 3 && !busy) gaps++;
                end
            end
        join
        check("b2b_loads", nl, 3);
        check("b2b_dones", nd, 3);
        check("b2b_val0", int'(lv[0]), 3);
        check("b2b_val1", int'(lv[1]), 0);
        check("b2b_val2", int'(lv[2]), 5);
        check("b2b_zero_latency", dc[1] - lc[1], 2);
        check("b2b_next_load0", lc[1] - dc[0], 1);
        check("b2b_next_load1", lc[2] - dc[1], 1);
        check("b2b_idle_gaps", gaps, 0);
        check("b2b_runs", int'(runs_completed), (rc + 3) % 256);
        tick();

        // Six values under sustained req_valid: FIFO fills, backpressure, order kept.
        wait_idle();
        vals4[0] = 3'd6; vals4[1] = 3'd1; vals4[2] = 3'd2;
        vals4[3] = 3'd3; vals4[4] = 3'd4; vals4[5] = 3'd5;
        nl = 0; nd = 0; acc = 0; lds = 0; saw_nr = 0; occ_at = -1;
        fork
            begin
                for (int k = 0; k < 6; k++) push_hold(vals4[k]);
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    @(negedge clk);
                    if (cnt_load) begin
                        if (nl < 8) lv[nl] = cnt_count_to;
                        nl++; lds++;
                    end
                    if (!req_ready && !saw_nr) begin saw_nr = 1; occ_at = acc - lds; end
                    if (req_valid && req_ready) acc++;
                    if (run_done) nd++;
                end
            end
        join
        check("fill_saw_not_ready", int'(saw_nr), 1);
        check("fill_occ_at_not_ready", occ_at, DEPTH);
        check("fill_accepted", acc, 6);
        check("fill_loads", nl, 6);
        check("fill_dones", nd, 6);
        for (int k = 0; k < 6; k++) check("fill_order", int'(lv[k]), int'(vals4[k]));

        // Abort during the RUN of value 6 with two values queued.
        wait_idle();
        push_hold(3'd6); push_hold(3'd1); push_hold(3'd2);
        wait_until(2, "abort_run_seen");
        tick(); tick();
        rc = runs_completed;
        abort = 1'b1;
        @(negedge clk);
        check("abort_ready_low", int'(req_ready), 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_count_en", int'(cnt_count_en), 0);
        check("abort_load", int'(cnt_load), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_run_done", int'(run_done), 0);
        check("abort_count_to_held", int'(cnt_count_to), 6);
        nl = 0; nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cnt_load) nl++;
            if (run_done) nd++;
        end
        check("abort_no_loads", nl, 0);
        check("abort_no_dones", nd, 0);
        check("abort_runs", int'(runs_completed), rc);
        tick();

        // Asynchronous reset in the middle of a run, then a fresh run of 2.
        push_hold(3'd7);
        wait_until(2, "rst_run_seen");
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();
        push_hold(3'd2);
        wait_until(1, "rst_fresh_done");
        check("rst_fresh_runs", int'(runs_completed), 1);
        check("rst_fresh_counter", int'(cnt_q), 0);
        tick();

        // 256 zero-value runs: tally wraps to 0, each pulse a single cycle.
        wait_idle();
        pulse_reset();
        nd = 0; wide = 0; saw255 = 0; prev_rd = 0;
        fork
            begin
                for (int k = 0; k < 256; k++) push_hold(3'd0);
            end
            begin
                bit last = 0;
                for (int i = 0; i < 3000 && nd < 256; i++) begin
                    @(negedge clk);
                    if (run_done) nd++;
                    if (run_done && last) wide++;
                    if (runs_completed == 8'd255) saw255 = 1;
                    last = run_done;
                end
            end
        join
        @(negedge clk);
        check("wrap_dones", nd, 256);
        check("wrap_wide_pulses", wide, 0);
        check("wrap_saw_255", int'(saw255), 1);
        check("wrap_runs_zero", int'(runs_completed), 0);
        tick();

        // Randomized traffic with occasional aborts, checked by the model.
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_value = W'($urandom_range(0, 7));
            abort     = ($urandom_range(0, 39) == 0);
            tick();
        end
        req_valid = 1'b0;
        abort     = 1'b0;
        wait_idle();
        check("rand_drained", exp_q.size(), 0);
        check("rand_busy", int'(busy), 0);
        check("rand_runs", int'(runs_completed), int'(runs_model));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
